// File: rtl/btb_pkg.sv
// Shared sizing helpers for the set-associative branch target buffer.
package btb_pkg;

  function automatic int BTB_S_TAG(input int s_index);
    return 32 - s_index - 2;
  endfunction

  function automatic int plru_nodes(input int ways);
    return ways - 1;
  endfunction

  function automatic int ctr_init(input int ctr_bits);
    return 1 << (ctr_bits - 1);
  endfunction

endpackage

// File: rtl/btb_plru_tree.sv
// Tree-PLRU for one set: next node bits after touching a way, plus the current victim.
// Purely combinational; no handshake.
module btb_plru_tree
  import btb_pkg::*;
#(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         plru_in,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  output logic [WAYS-2:0]         plru_out,
  output logic [$clog2(WAYS)-1:0] victim_way
);
  localparam int WL    = $clog2(WAYS);
  localparam int NODES = plru_nodes(WAYS);

  // Node on level l of the touched path is (2^l - 1) + (way's top l bits).
  always_comb begin
    plru_out = plru_in;
    for (int n = 0; n < NODES; n++) begin
      for (int l = 0; l < WL; l++) begin
        if (n == ((1 << l) - 1 + int'(touch_way >> (WL - l))))
          plru_out[n] = ~touch_way[WL-1-l];
      end
    end
  end

  always_comb begin
    logic w_bit;
    victim_way = '0;
    for (int l = 0; l < WL; l++) begin
      w_bit = 1'b0;
      for (int n = 0; n < NODES; n++) begin
        if (n == ((1 << l) - 1 + int'(victim_way)))
          w_bit = plru_in[n];
      end
      victim_way    = victim_way << 1;
      victim_way[0] = w_bit;
    end
  end

endmodule

// File: rtl/btb_nway.sv
// N-way set-associative BTB with tree-PLRU replacement and saturating direction counters.
// Lookup response registered one cycle after request; no backpressure, one lookup and one update per cycle.
module btb_nway
  import btb_pkg::*;
#(
  parameter int S_INDEX  = 3,
  parameter int WAYS     = 4,
  parameter int TARGET_W = 32,
  parameter int CTR_BITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    lookup_valid,
  input  logic [31:0]             lookup_pc,
  output logic                    resp_valid,
  output logic                    resp_hit,
  output logic                    resp_taken,
  output logic [TARGET_W-1:0]     resp_target,
  output logic [$clog2(WAYS)-1:0] resp_way,
  input  logic                    upd_valid,
  input  logic [31:0]             upd_pc,
  input  logic                    upd_taken,
  input  logic [TARGET_W-1:0]     upd_target
);
  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = BTB_S_TAG(S_INDEX);
  localparam int NODES = plru_nodes(WAYS);
  localparam int WL    = $clog2(WAYS);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [TARGET_W-1:0] target;
  } entry_t;

  logic [SETS-1:0][WAYS-1:0]               r_valid;
  logic [SETS-1:0][WAYS-1:0][CTR_BITS-1:0] r_ctr;
  logic [SETS-1:0][NODES-1:0]              r_plru;
  entry_t                                  r_ent [SETS][WAYS];

  logic                r_resp_valid, r_resp_hit, r_resp_taken;
  logic [TARGET_W-1:0] r_resp_target;
  logic [WL-1:0]       r_resp_way;

  logic [S_INDEX-1:0]  w_lk_set, w_up_set;
  logic [TAG_W-1:0]    w_lk_tag, w_up_tag;
  logic                w_lk_hit, w_lk_touch;
  logic [WL-1:0]       w_lk_way, w_unused_lk_victim;
  logic [NODES-1:0]    w_lk_plru, w_up_plru;
  logic                w_up_hit, w_up_has_inv, w_up_touch;
  logic [WL-1:0]       w_up_hit_way, w_up_inv_way, w_up_victim, w_up_way;
  logic [CTR_BITS-1:0] w_up_ctr, w_up_ctr_next;
  logic                w_unused_pc;

  assign w_unused_pc = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign w_lk_set = lookup_pc[S_INDEX+1:2];
  assign w_lk_tag = lookup_pc[31:S_INDEX+2];
  assign w_up_set = upd_pc[S_INDEX+1:2];
  assign w_up_tag = upd_pc[31:S_INDEX+2];

  // Descending scans leave the lowest matching index as the winner.
  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_lk_set][w] && (r_ent[w_lk_set][w].tag == w_lk_tag)) begin
        w_lk_hit = 1'b1;
        w_lk_way = WL'(w);
      end
    end
  end

  always_comb begin
    w_up_hit     = 1'b0;
    w_up_hit_way = '0;
    w_up_has_inv = 1'b0;
    w_up_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_up_set][w] && (r_ent[w_up_set][w].tag == w_up_tag)) begin
        w_up_hit     = 1'b1;
        w_up_hit_way = WL'(w);
      end
      if (!r_valid[w_up_set][w]) begin
        w_up_has_inv = 1'b1;
        w_up_inv_way = WL'(w);
      end
    end
  end

  always_comb begin
    w_up_way = w_up_victim;
    if (w_up_hit)
      w_up_way = w_up_hit_way;
    else if (w_up_has_inv)
      w_up_way = w_up_inv_way;
  end

  assign w_up_ctr = r_ctr[w_up_set][w_up_hit_way];

  always_comb begin
    w_up_ctr_next = w_up_ctr;
    if (upd_taken && (w_up_ctr != CTR_MAX))
      w_up_ctr_next = w_up_ctr + 1'b1;
    else if (!upd_taken && (w_up_ctr != '0))
      w_up_ctr_next = w_up_ctr - 1'b1;
  end

  assign w_lk_touch = lookup_valid & w_lk_hit;
  assign w_up_touch = upd_valid & (w_up_hit | upd_taken);

  btb_plru_tree #(.WAYS(WAYS)) u_plru_lk (
    .plru_in    (r_plru[w_lk_set]),
    .touch_way  (w_lk_way),
    .plru_out   (w_lk_plru),
    .victim_way (w_unused_lk_victim)
  );

  btb_plru_tree #(.WAYS(WAYS)) u_plru_up (
    .plru_in    (r_plru[w_up_set]),
    .touch_way  (w_up_way),
    .plru_out   (w_up_plru),
    .victim_way (w_up_victim)
  );

  // Update's PLRU write is issued last so it wins when both touch one set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid       <= '0;
      r_ctr         <= '0;
      r_plru        <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_hit    <= 1'b0;
      r_resp_taken  <= 1'b0;
      r_resp_target <= '0;
      r_resp_way    <= '0;
    end else if (flush) begin
      r_valid       <= '0;
      r_plru        <= '0;
      r_resp_valid  <= lookup_valid;
      r_resp_hit    <= 1'b0;
      r_resp_taken  <= 1'b0;
      r_resp_target <= '0;
      r_resp_way    <= '0;
    end else begin
      r_resp_valid  <= lookup_valid;
      r_resp_hit    <= w_lk_touch;
      r_resp_taken  <= w_lk_touch & r_ctr[w_lk_set][w_lk_way][CTR_BITS-1];
      r_resp_target <= w_lk_touch ? r_ent[w_lk_set][w_lk_way].target : '0;
      r_resp_way    <= w_lk_touch ? w_lk_way : '0;
      if (w_lk_touch)
        r_plru[w_lk_set] <= w_lk_plru;
      if (w_up_touch) begin
        r_plru[w_up_set]            <= w_up_plru;
        r_valid[w_up_set][w_up_way] <= 1'b1;
        r_ctr[w_up_set][w_up_way]   <= w_up_hit ? w_up_ctr_next : CTR_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && w_up_touch) begin
      r_ent[w_up_set][w_up_way].tag    <= w_up_tag;
      r_ent[w_up_set][w_up_way].target <= upd_target;
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_hit    = r_resp_hit;
  assign resp_taken  = r_resp_taken;
  assign resp_target = r_resp_target;
  assign resp_way    = r_resp_way;

endmodule

// File: tb/tb_btb_nway.sv
// Randomized scoreboard bench for btb_nway against a range-halving PLRU reference model.
module tb_btb_nway;
  localparam int SI   = 3;
  localparam int NW   = 4;
  localparam int CB   = 2;
  localparam int SETS = 1 << SI;
  localparam int CMAX = (1 << CB) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        resp_valid, resp_hit, resp_taken;
  logic [31:0] resp_target;
  logic [1:0]  resp_way;

  btb_nway #(.S_INDEX(SI), .WAYS(NW), .TARGET_W(32), .CTR_BITS(CB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_taken(resp_taken),
    .resp_target(resp_target), .resp_way(resp_way),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          hit;
    bit          taken;
    logic [31:0] tgt;
    int          way;
  } exp_t;
  exp_t exp_q[$];

  bit          m_valid [SETS][NW];
  logic [31:0] m_tag   [SETS][NW];
  logic [31:0] m_tgt   [SETS][NW];
  int          m_ctr   [SETS][NW];
  int          m_plru  [SETS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int plru_touch(input int p, input int way);
    int lo = 0, hi = NW, node = 0, mid, r = p;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (way < mid) begin r = r | (1 << node);  hi = mid; node = 2 * node + 1; end
      else           begin r = r & ~(1 << node); lo = mid; node = 2 * node + 2; end
    end
    return r;
  endfunction

  function automatic int plru_victim(input int p);
    int lo = 0, hi = NW, node = 0, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (((p >> node) & 1) == 1) begin lo = mid; node = 2 * node + 2; end
      else                        begin hi = mid; node = 2 * node + 1; end
    end
    return lo;
  endfunction

  function automatic void model_clear(input bit ctrs);
    for (int s = 0; s < SETS; s++) begin
      m_plru[s] = 0;
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 1'b0;
        if (ctrs) m_ctr[s][w] = 0;
      end
    end
  endfunction

  // Applies the inputs sampled at this clock edge to the reference state.
  function automatic void model_step();
    int   ls, us, lw, uw, inv, lk_plru;
    bit   lhit, uhit, utouch;
    exp_t e;
    if (!rst) begin model_clear(1'b1); return; end
    if (flush) begin
      if (lookup_valid) begin e = '{0, 0, 32'h0, 0}; exp_q.push_back(e); end
      model_clear(1'b0);
      return;
    end
    ls = int'(lookup_pc[SI+1:2]);
    lhit = 0; lw = 0;
    for (int w = 0; w < NW; w++)
      if (!lhit && m_valid[ls][w] && m_tag[ls][w] == (lookup_pc >> (SI + 2))) begin lhit = 1; lw = w; end
    if (lookup_valid) begin
      if (lhit) e = '{1, m_ctr[ls][lw] >= (1 << (CB - 1)), m_tgt[ls][lw], lw};
      else      e = '{0, 0, 32'h0, 0};
      exp_q.push_back(e);
    end
    lk_plru = plru_touch(m_plru[ls], lw);
    us = int'(upd_pc[SI+1:2]);
    uhit = 0; uw = 0; inv = -1;
    for (int w = 0; w < NW; w++) begin
      if (!uhit && m_valid[us][w] && m_tag[us][w] == (upd_pc >> (SI + 2))) begin uhit = 1; uw = w; end
      if (inv < 0 && !m_valid[us][w]) inv = w;
    end
    utouch = upd_valid && (uhit || upd_taken);
    if (lookup_valid && lhit && !(utouch && us == ls)) m_plru[ls] = lk_plru;
    if (utouch) begin
      if (uhit) begin
        if (upd_taken) m_ctr[us][uw] = (m_ctr[us][uw] < CMAX) ? m_ctr[us][uw] + 1 : CMAX;
        else           m_ctr[us][uw] = (m_ctr[us][uw] > 0) ? m_ctr[us][uw] - 1 : 0;
      end else begin
        uw = (inv >= 0) ? inv : plru_victim(m_plru[us]);
        m_valid[us][uw] = 1'b1;
        m_tag[us][uw]   = upd_pc >> (SI + 2);
        m_ctr[us][uw]   = 1 << (CB - 1);
      end
      m_tgt[us][uw] = upd_target;
      m_plru[us] = plru_touch(m_plru[us], uw);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit lv, input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                       input bit ut, input logic [31:0] utgt, input bit fl);
    lookup_valid = lv; lookup_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    flush = fl;
    tick();
    lookup_valid = 0; upd_valid = 0; flush = 0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    drive(1, pc, 0, 0, 0, 0, 0);
  endtask

  task automatic update(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
    drive(0, 0, 1, pc, t, tgt, 0);
  endtask

  task automatic do_reset_check(input string tag);
    rst = 0;
    tick();
    rst = 1;
    #1;
    chk({tag, "_valid"},  32'(resp_valid), 32'h0);
    chk({tag, "_hit"},    32'(resp_hit), 32'h0);
    chk({tag, "_taken"},  32'(resp_taken), 32'h0);
    chk({tag, "_target"}, resp_target, 32'h0);
    chk({tag, "_way"},    32'(resp_way), 32'h0);
  endtask

  // Monitor: every presented response is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_hit",    32'(resp_hit), 32'(e.hit));
          chk("resp_taken",  32'(resp_taken), 32'(e.taken));
          chk("resp_target", resp_target, e.tgt);
          chk("resp_way",    32'(resp_way), 32'(e.way));
        end
      end else if (exp_q.size() != 0) begin
        chk("missing_resp", 32'(resp_valid), 32'h1);
        exp_q.delete();
      end
    end
  end

  initial begin
    logic [31:0] pa, pb;
    model_clear(1'b1);
    tick();
    do_reset_check("reset");

    lookup(32'h40);
    update(32'h40, 1, 32'h100);
    lookup(32'h40);
    update(32'h40, 0, 32'h100);
    update(32'h40, 0, 32'h100);
    lookup(32'h40);
    update(32'h40, 0, 32'h100);
    lookup(32'h40);
    for (int i = 0; i < 4; i++) update(32'h40, 1, 32'h100);
    lookup(32'h40);

    do_reset_check("reset2");
    update(32'h000, 1, 32'hA0);
    update(32'h020, 1, 32'hA1);
    update(32'h040, 1, 32'hA2);
    update(32'h060, 1, 32'hA3);
    lookup(32'h000);
    update(32'h080, 1, 32'hA4);
    lookup(32'h040);
    lookup(32'h000);
    lookup(32'h080);
    lookup(32'h060);

    do_reset_check("reset3");
    update(32'h40, 1, 32'h100);
    drive(1, 32'h40, 1, 32'h40, 1, 32'h200, 0);
    lookup(32'h40);
    drive(1, 32'h40, 1, 32'h80, 1, 32'h300, 1);
    lookup(32'h40);
    lookup(32'h80);

    for (int i = 0; i < 4000; i++) begin
      pa = 32'($urandom_range(0, 63)) << 2;
      pb = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 3) == 0) pb = pa;
      if ($urandom_range(0, 7) == 0) pa = pa | 32'h8000_0000;
      if ($urandom_range(0, 599) == 0) begin
        do_reset_check("reset_rand");
      end else begin
        drive($urandom_range(0, 9) < 7, pa, $urandom_range(0, 9) < 6, pb,
              $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 199) == 0);
      end
    end

    tick();
    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btb_nway.md
Name: btb_nway

Overview:
- Parametrised next-generation branch target buffer for the RV32I fetch stage.
- N-way set-associative, with a generalised tree-PLRU replacement policy and a per-entry saturating direction counter.
- Registered one-cycle lookup response, and a single-cycle flush.
- Fetch issues lookups; the execute/branch-resolve stage issues updates.

Parameters:
- S_INDEX, 3, log2 of set count; index = pc[S_INDEX+1:2].
- WAYS, 4, associativity; power of 2, range 2..16.
- TARGET_W, 32, stored target width.
- CTR_BITS, 2, saturating direction counter width (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (0 = reset).
- flush  in  1  invalidate all entries.
- lookup_valid  in  1  lookup request this cycle.
- lookup_pc  in  32  fetch PC.
- resp_valid  out  1  response for the previous cycle's lookup.
- resp_hit  out  1  tag match on a valid entry.
- resp_taken  out  1  counter MSB of the hit entry; 0 on miss.
- resp_target  out  TARGET_W  target of the hit entry; 0 on miss.
- resp_way  out  $clog2(WAYS)  way that hit; 0 on miss.
- upd_valid  in  1  resolved branch update.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  resolved direction.
- upd_target  in  TARGET_W  resolved target.

Behaviour:
- Storage:
  - Per set and way: valid, tag (32-S_INDEX-2 bits), target, counter.
  - Per set: WAYS-1 PLRU bits.
  - All storage is flops.
- Reset (rst=0 at posedge):
  - All valid bits, counters and PLRU bits clear to 0.
  - resp_valid, resp_hit, resp_taken, resp_target and resp_way register to 0.
- Lookup latency is 1 cycle:
  - A request at edge N produces its resp_* fields from edge N+1 onward, holding for one cycle.
  - resp_valid = the lookup_valid registered at N.
  - If several ways match (must not occur), the lowest-index way wins.
- Read-before-write: a lookup and an update to the same set in the same cycle return the pre-update state.
- PLRU tree:
  - Node i has children 2i+1 and 2i+2. A node bit of 0 means the victim lies left; 1 means right.
  - Touching a way sets every node on its path to point away from it.
  - Victim: walk from the root following the node bits.
- Lookup hit: touch the hit way's PLRU on the same edge the response registers.
- Update hit (valid and tag match):
  - Write the target.
  - Counter: +1 if upd_taken, -1 if not, saturating at 0 and 2^CTR_BITS-1.
  - Touch the PLRU.
- Update miss with upd_taken=1:
  - Allocate the lowest-index invalid way; if none is invalid, the PLRU victim.
  - Write tag and target, set valid, set counter = 2^(CTR_BITS-1) (weakly taken).
  - Touch the PLRU.
- Update miss with upd_taken=0: no state change.
- Lookup hit and update touching the same set in the same cycle: the PLRU write from the update takes priority. Different sets: both touches apply.
- Flush:
  - Clears all valid bits and PLRU bits at the edge.
  - Concurrent updates are dropped.
  - A concurrent lookup registers resp_valid=1 with resp_hit=0.
  - Counters and targets are unchanged (don't-care while invalid).
- Reset overrides flush, update and lookup.
- Address wrap: no special case; the tag is pc[31:S_INDEX+2].

Decomposition:
- Add constants and helpers to rv32i_types or a new btb_pkg: BTB_S_TAG(S_INDEX), plru_nodes(WAYS) = WAYS-1, ctr_init(CTR_BITS).
- The entry struct is declared locally because its widths are parameter-dependent.
- One sub-module: btb_plru_tree.
  - Parameter WAYS.
  - Inputs: plru_in, touch_way.
  - Outputs: plru_out (combinational next bits), victim_way.
  - Two instances: one for lookup touch, one for update allocation and touch.

Test Plan:
- Reset then lookup pc=0x0000_0040 -> next cycle resp_valid=1, resp_hit=0, resp_target=0.
- upd pc=0x40, taken=1, target=0x100; then lookup 0x40 -> resp_hit=1, resp_target=0x100, resp_taken=1 (ctr=2).
- Two not-taken updates to 0x40, then lookup -> hit, ctr=0, resp_taken=0; a third not-taken keeps ctr=0 (saturation). Four taken updates -> ctr=3.
- WAYS=4 set 0:
  - Allocate 0x000, 0x020, 0x040, 0x060 (ways 0-3), then lookup-hit way 0.
  - Then allocate 0x080 -> evicts the PLRU victim way 2.
  - Lookup 0x040 -> miss; 0x000 -> still hit.
- Same-cycle lookup and update on 0x40 with a new target 0x200 -> response shows the old target 0x100; next lookup shows 0x200.
- flush with a simultaneous taken update to 0x80 -> all lookups miss afterwards, including 0x80. rst=0 mid-traffic -> outputs 0 next cycle.
